// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO family.
package fifo_pkg;

    // Read-mode selector values for the FWFT parameter.
    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Ceiling log2, used to size RAM addresses from a word count.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sdp_ram_1clk.sv
// Simple dual-port RAM on one clock: one write port, one read port with a
// registered, enable-gated output. A read and a write to the same address in
// the same cycle return the previously stored word.
module sdp_ram_1clk
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 1024,
    localparam int ADDR_WIDTH = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_dout;

    // Write port: store din when we is high. No reset so it maps to block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= din;
        end
    end

    // Read port: output register loads only on re and otherwise holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout <= '0;
        end else if (re) begin
            r_dout <= r_mem[raddr];
        end
    end

    assign dout = r_dout;

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with selectable standard or first-word-fall-through read,
// full-range occupancy count, runtime almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and synchronous flush.
//
// Handshake: a write is taken on a clock edge when wr_en = 1 and the registered
// full = 0; a read/pop is taken when rd_en = 1 and the registered empty = 0.
// A request against full/empty is dropped and latches overflow/underflow.
// flush overrides both requests in the same cycle.
module sync_fifo_fwft
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH_WIDTH = 10,
    parameter int FWFT        = FIFO_MODE_STD
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic                   rd_en,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   rd_valid,
    output logic                   full,
    output logic                   empty,
    input  logic [DEPTH_WIDTH:0]   afull_thresh,
    input  logic [DEPTH_WIDTH:0]   aempty_thresh,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [DEPTH_WIDTH:0]   count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int                 DEPTH     = 1 << DEPTH_WIDTH;
    localparam bit                 IS_FWFT   = (FWFT == FIFO_MODE_FWFT);
    localparam logic [DEPTH_WIDTH:0] DEPTH_CNT = (DEPTH_WIDTH + 1)'(DEPTH);
    localparam logic [DEPTH_WIDTH:0] CNT_ONE   = (DEPTH_WIDTH + 1)'(1);

    // Pointers carry one extra bit so a full RAM and an empty RAM differ.
    logic [DEPTH_WIDTH:0]  r_wr_ptr;
    logic [DEPTH_WIDTH:0]  r_rd_ptr;
    logic [DEPTH_WIDTH:0]  r_count;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_afull;
    logic                  r_aempty;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  r_rd_valid;

    logic                  w_wr_ok;
    logic                  w_rd_ok;
    logic                  w_ram_has;
    logic                  w_fetch;
    logic [DEPTH_WIDTH:0]  w_count_nxt;
    logic                  w_empty_nxt;
    logic                  w_rd_valid_nxt;
    logic [DATA_WIDTH-1:0] w_ram_dout;

    // Acceptance is judged on registered flags only.
    assign w_wr_ok   = wr_en & ~r_full & ~flush;
    assign w_rd_ok   = rd_en & ~r_empty & ~flush;

    // Words sitting in RAM that have not yet been moved to the read register.
    assign w_ram_has = (r_wr_ptr != r_rd_ptr);

    // RAM read issue. Standard mode reads on each accepted request. FWFT mode
    // refills the output register whenever it is empty or being popped and the
    // RAM holds a word written in an earlier cycle, which keeps a steady pop
    // stream bubble-free and never reads the address being written.
    assign w_fetch = IS_FWFT ? (w_ram_has & (r_empty | w_rd_ok) & ~flush)
                             : w_rd_ok;

    // Next occupancy: simultaneous accepted write and read cancel out.
    always_comb begin
        w_count_nxt = r_count;
        if (flush) begin
            w_count_nxt = '0;
        end else if (w_wr_ok && !w_rd_ok) begin
            w_count_nxt = r_count + CNT_ONE;
        end else if (!w_wr_ok && w_rd_ok) begin
            w_count_nxt = r_count - CNT_ONE;
        end
    end

    // Next empty: in FWFT mode it tracks the output register, otherwise count.
    always_comb begin
        w_empty_nxt = r_empty;
        if (flush) begin
            w_empty_nxt = 1'b1;
        end else if (IS_FWFT) begin
            if (w_fetch) begin
                w_empty_nxt = 1'b0;
            end else if (w_rd_ok) begin
                w_empty_nxt = 1'b1;
            end
        end else begin
            w_empty_nxt = (w_count_nxt == '0);
        end
    end

    // Next rd_valid: a one-cycle pulse per read, or the FWFT head-valid flag.
    always_comb begin
        w_rd_valid_nxt = 1'b0;
        if (IS_FWFT) begin
            w_rd_valid_nxt = ~w_empty_nxt;
        end else begin
            w_rd_valid_nxt = w_rd_ok;
        end
    end

    // Pointer update; flush returns both to the start of the RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + CNT_ONE;
            end
            if (w_fetch) begin
                r_rd_ptr <= r_rd_ptr + CNT_ONE;
            end
        end
    end

    // Count and all level flags, registered together from the next count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_afull    <= 1'b0;
            r_aempty   <= 1'b1;
            r_rd_valid <= 1'b0;
        end else begin
            r_count    <= w_count_nxt;
            r_full     <= (w_count_nxt == DEPTH_CNT);
            r_empty    <= w_empty_nxt;
            r_afull    <= (w_count_nxt >= afull_thresh);
            r_aempty   <= (w_count_nxt <= aempty_thresh);
            r_rd_valid <= w_rd_valid_nxt;
        end
    end

    // Sticky error flags, cleared only by reset or flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && r_full) begin
                r_overflow <= 1'b1;
            end
            if (rd_en && r_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // The RAM output register doubles as the read data / FWFT head register.
    sdp_ram_1clk #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (w_wr_ok),
        .waddr (r_wr_ptr[DEPTH_WIDTH-1:0]),
        .din   (wr_data),
        .re    (w_fetch),
        .raddr (r_rd_ptr[DEPTH_WIDTH-1:0]),
        .dout  (w_ram_dout)
    );

    assign rd_data      = w_ram_dout;
    assign rd_valid     = r_rd_valid;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_afull;
    assign almost_empty = r_aempty;
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: doc/sync_fifo_fwft.md
Name: sync_fifo_fwft

Overview:
- Single-clock, parametrised FIFO for the pixel and packet paths that live inside one clock domain (camera capture to line buffer, DDR read-back to HDMI timing).
- Successor to the team's dual-clock FIFO, with these additions:
  - selectable standard or first-word-fall-through (FWFT) read mode;
  - full-range occupancy count;
  - runtime almost-full / almost-empty thresholds;
  - sticky overflow / underflow flags;
  - synchronous flush.
- Storage is inferred block RAM with a registered read port.

Parameters:
DATA_WIDTH, 16, width of each stored word.
DEPTH_WIDTH, 10, log2 of capacity; DEPTH = 2**DEPTH_WIDTH words.
FWFT, 0, 0 = standard read (1-cycle latency); 1 = first-word-fall-through.

Ports:
clk  in  1  single clock; all logic on posedge.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  synchronous clear of FIFO contents and flags.
wr_en  in  1  write request.
wr_data  in  DATA_WIDTH  write data.
rd_en  in  1  read request (standard mode) / pop (FWFT mode).
rd_data  out  DATA_WIDTH  read data.
rd_valid  out  1  standard mode: 1-cycle pulse, rd_data valid; FWFT mode: equals ~empty.
full  out  1  count == DEPTH.
empty  out  1  no word available to the reader.
afull_thresh  in  DEPTH_WIDTH+1  almost_full threshold.
aempty_thresh  in  DEPTH_WIDTH+1  almost_empty threshold.
almost_full  out  1  count >= afull_thresh.
almost_empty  out  1  count <= aempty_thresh.
count  out  DEPTH_WIDTH+1  words held, range 0..DEPTH.
overflow  out  1  sticky: a write was attempted while full.
underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset values (async, rst_n low):
  - pointers = 0, count = 0, rd_data = 0, rd_valid = 0;
  - full = 0, empty = 1, almost_full = 0, almost_empty = 1;
  - overflow = 0, underflow = 0.
- All outputs are registered.
- Pointers are DEPTH_WIDTH+1 bits in binary. RAM address is the low DEPTH_WIDTH bits. Wrap-around is natural modulo 2**(DEPTH_WIDTH+1).
- Write acceptance: wr_ok = wr_en & ~full, evaluated on the registered full.
  - A write while full is dropped and sets overflow, even if a read occurs in the same cycle.
- Read acceptance: rd_ok = rd_en & ~empty, evaluated on the registered empty.
  - A read while empty is dropped and sets underflow, even if a write occurs in the same cycle.
- count update: +1 on wr_ok only, -1 on rd_ok only, unchanged when both fire.
  - full, almost_full and almost_empty are computed from the next count and registered in the same cycle as count.
- Standard mode (FWFT = 0):
  - rd_ok in cycle N → rd_data holds the head word and rd_valid = 1 in cycle N+1.
  - rd_data holds its value until the next accepted read.
  - empty = (count == 0).
  - Write-to-read: a word written in cycle N may be read from cycle N+1.
- FWFT mode (FWFT = 1):
  - An output register holds the head word. rd_data is valid whenever empty = 0.
  - rd_en pops the head word. The next word is in rd_data in cycle N+1 if one is available in RAM; otherwise empty rises in N+1.
  - A write to an empty FIFO in cycle N gives empty = 0 at cycle N+2 (RAM read, then output load).
  - count includes the word in the output register, so capacity is DEPTH in both modes.
  - empty is the output-register-valid flag, not count == 0. The bench must allow count = 1 while empty = 1 for up to 2 cycles after a write.
  - Sustained rd_en at 1 word per cycle with no bubbles while the RAM holds data.
- Flush:
  - Takes priority over wr_en/rd_en in the same cycle.
  - Clears pointers, count, overflow and underflow, and the FWFT output valid.
  - Sets empty = 1 and clears full; almost_full/almost_empty re-evaluate against count = 0.
  - rd_data is not cleared. rd_valid = 0 next cycle.
- Thresholds:
  - Sampled every cycle; a change takes effect on the next registered flag update.
  - afull_thresh = 0 forces almost_full = 1.
  - aempty_thresh >= DEPTH forces almost_empty = 1.
- Overflow/underflow clear only on reset or flush.

Decomposition:
- fifo_pkg holds:
  - mode constants FIFO_MODE_STD = 0 and FIFO_MODE_FWFT = 1;
  - function clog2.
- One sub-module, sdp_ram_1clk: simple dual-port RAM on one clock.
  - Write port: we, waddr, din.
  - Read port: re, raddr, with registered dout, 1-cycle latency and read-enable gating.
  - Read-during-write to the same address returns the old data. The FIFO never issues that case for a live word.
- FWFT output register, pointer logic, count and flags live in sync_fifo_fwft.

Test Plan:
1. DATA_WIDTH=16, DEPTH_WIDTH=4, FWFT=0: write 0x0001..0x0010 → full = 1 and count = 16 after the 16th write. A 17th write leaves count at 16 and sets overflow = 1. Then read 16 words → rd_data = 0x0001..0x0010 in order with rd_valid pulses, and empty = 1 after the last read.
2. Same config: read on empty → underflow = 1, count stays 0, rd_valid stays 0. Then flush → underflow = 0.
3. FWFT=1, write 0xABCD at cycle N into an empty FIFO → empty = 0 and rd_data = 0xABCD at N+2. Then continuous wr_en and rd_en for 100 cycles → count is stable, data is in order, no dropped words.
4. Simultaneous wr_en and rd_en:
   - at count = 16 (full) → read accepted, write dropped, count = 15, overflow = 1;
   - at count = 0 → write accepted, read dropped, count = 1, underflow = 1.
5. afull_thresh = 12, aempty_thresh = 3: fill, then drain → almost_full rises on the cycle count becomes 12; almost_empty is 1 through count = 3, falls at count = 4, and rises again when draining back to count = 3.
6. Assert rst_n low mid-burst at count = 9 → all outputs return to reset values immediately (asynchronously). After release, write 0x0055 → it is read back first.
